// File: rtl/bcd_dabble16.sv
// Sequential 16-bit binary to 5-digit packed BCD converter (double dabble, one bit per clock).
// Optional ndig output (significant digit count) is enabled by defining BCD_CVT_NDIG_EN.
module bcd_dabble16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] bin_in,
   output logic        busy,
   output logic        done,
   output logic [19:0] bcd_out
`ifdef BCD_CVT_NDIG_EN
   ,
   output logic [2:0]  ndig
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] shift_q, shift_d;
   logic [19:0] scratch_q, scratch_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [19:0] bcd_q, bcd_d;

   logic [19:0] adj;
   logic [35:0] shifted;
   logic [19:0] result;
   logic        unused_top;

   // Add-3 correction on every digit in parallel, ahead of the shift.
   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_dig
         assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                                 (scratch_q[gi*4 +: 4] + 4'd3) :
                                 scratch_q[gi*4 +: 4];
      end
   endgenerate

   // The top digit never exceeds 6, so its MSB is never shifted out meaningfully.
   assign shifted    = {adj[18:0], shift_q, 1'b0};
   assign result     = shifted[35:16];
   assign unused_top = adj[19];

`ifdef BCD_CVT_NDIG_EN
   logic [2:0] ndig_q, ndig_d;
   logic [2:0] ndig_calc;

   always_comb begin
      ndig_calc = 3'd1;
      if (result[19:16] != 4'd0)
         ndig_calc = 3'd5;
      else if (result[15:12] != 4'd0)
         ndig_calc = 3'd4;
      else if (result[11:8] != 4'd0)
         ndig_calc = 3'd3;
      else if (result[7:4] != 4'd0)
         ndig_calc = 3'd2;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= 16'd0;
         scratch_q <= 20'd0;
         cnt_q     <= 5'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= 20'd0;
`ifdef BCD_CVT_NDIG_EN
         ndig_q    <= 3'd1;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
`ifdef BCD_CVT_NDIG_EN
         ndig_q    <= ndig_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
`ifdef BCD_CVT_NDIG_EN
      ndig_d    = ndig_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            // DONE accepts a new request directly so conversions can run back-to-back.
            if (start) begin
               shift_d   = bin_in;
               scratch_d = 20'd0;
               cnt_d     = 5'd16;
               busy_d    = 1'b1;
               state_d   = SHIFT;
            end else begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         SHIFT: begin
            scratch_d = result;
            shift_d   = shifted[15:0];
            cnt_d     = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               bcd_d   = result;
`ifdef BCD_CVT_NDIG_EN
               ndig_d  = ndig_calc;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bcd_out = bcd_q;
`ifdef BCD_CVT_NDIG_EN
   assign ndig    = ndig_q;
`endif

endmodule

// File: tb/tb_bcd_dabble16.sv
// Self-checking bench for bcd_dabble16: decimal-arithmetic reference model plus directed vectors.
module tb_bcd_dabble16;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] bin_in;
   logic        busy;
   logic        done;
   logic [19:0] bcd_out;
`ifdef BCD_CVT_NDIG_EN
   logic [2:0]  ndig;
`endif

   bcd_dabble16 dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out)
`ifdef BCD_CVT_NDIG_EN
      ,
      .ndig    (ndig)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int cyc      = 0;
   int done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int d;
      r = 20'd0;
      d = v;
      for (int k = 0; k < 5; k++) begin
         r[k*4 +: 4] = 4'(d % 10);
         d = d / 10;
      end
      return r;
   endfunction

   function automatic int ndig_of(input int v);
      if (v >= 10000) return 5;
      if (v >= 1000)  return 4;
      if (v >= 100)   return 3;
      if (v >= 10)    return 2;
      return 1;
   endfunction

   // Reference model: a request is taken whenever no conversion is pending,
   // and its result appears exactly 16 clocks later.
   int          m_cnt;
   int          m_val;
   logic        m_done;
   logic [19:0] m_bcd;
   int          m_ndig;
   logic        m_acc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt  = 0;
         m_val  = 0;
         m_done = 1'b0;
         m_bcd  = 20'd0;
         m_ndig = 1;
      end else begin
         m_acc  = start && (m_cnt == 0);
         m_done = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_done = 1'b1;
               m_bcd  = to_bcd(m_val);
               m_ndig = ndig_of(m_val);
            end
         end
         if (m_acc) begin
            m_cnt = 16;
            m_val = int'(bin_in);
         end
      end
   end

   always @(posedge clk) cyc++;

   logic prev_done = 1'b0;
   logic nib_ok;

   always @(posedge clk) begin
      #2;
      chk("busy", 32'(busy), 32'(m_cnt != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
`ifdef BCD_CVT_NDIG_EN
      chk("ndig", 32'(ndig), 32'(m_ndig));
`endif
      nib_ok = 1'b1;
      for (int k = 0; k < 5; k++)
         if (bcd_out[k*4 +: 4] > 4'd9) nib_ok = 1'b0;
      chk("nibble_le9", 32'(nib_ok), 32'd1);
      chk("busy_done_excl", 32'(busy && done), 32'd0);
      chk("done_single", 32'(done && prev_done), 32'd0);
      prev_done = done;
      if (done) begin
         done_cnt++;
         $display("txn %0d: bin=%0d bcd_out=%05h", done_cnt, m_val, bcd_out);
      end
   end

   task automatic wait_done(output int tdone);
      for (int n = 0; n < 40; n++) begin
         if (done) begin
            tdone = cyc;
            return;
         end
         @(negedge clk);
      end
      chk("done_timeout", 32'd0, 32'd1);
      tdone = cyc;
   endtask

   task automatic accept(input logic [15:0] v, output int t0);
      @(negedge clk);
      start  = 1'b1;
      bin_in = v;
      @(negedge clk);
      start  = 1'b0;
      t0     = cyc;
   endtask

   int t0, t1, t2, d0;
   logic [15:0] sweep_q[$];

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      bin_in = 16'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", 32'(bcd_out), 32'h00000);
`ifdef BCD_CVT_NDIG_EN
      chk("rst_ndig", 32'(ndig), 32'd1);
`endif
      rst = 1'b0;

      // Zero input, latency
      accept(16'd0, t0);
      wait_done(t1);
      chk("lat_zero", 32'(t1 - t0), 32'd16);
      chk("bcd_zero", 32'(bcd_out), 32'h00000);
`ifdef BCD_CVT_NDIG_EN
      chk("ndig_zero", 32'(ndig), 32'd1);
`endif

      accept(16'd65535, t0);
      wait_done(t1);
      chk("bcd_max", 32'(bcd_out), 32'h65535);
`ifdef BCD_CVT_NDIG_EN
      chk("ndig_max", 32'(ndig), 32'd5);
`endif

      accept(16'd12345, t0);
      wait_done(t1);
      chk("bcd_12345", 32'(bcd_out), 32'h12345);

      // Start while busy is ignored
      accept(16'd100, t0);
      d0 = done_cnt;
      repeat (4) @(negedge clk);
      start  = 1'b1;
      bin_in = 16'd999;
      @(negedge clk);
      start  = 1'b0;
      wait_done(t1);
      chk("lat_ign", 32'(t1 - t0), 32'd16);
      chk("bcd_ign", 32'(bcd_out), 32'h00100);
`ifdef BCD_CVT_NDIG_EN
      chk("ndig_ign", 32'(ndig), 32'd3);
`endif
      repeat (20) @(negedge clk);
      chk("one_done_ign", 32'(done_cnt - d0), 32'd1);

      // Back-to-back start in the done cycle
      accept(16'd4095, t0);
      wait_done(t1);
      chk("bcd_4095", 32'(bcd_out), 32'h04095);
      start  = 1'b1;
      bin_in = 16'd9;
      @(negedge clk);
      start  = 1'b0;
      repeat (7) @(negedge clk);
      chk("bcd_hold", 32'(bcd_out), 32'h04095);
      wait_done(t2);
      chk("b2b_spacing", 32'(t2 - t1), 32'd17);
      chk("bcd_9", 32'(bcd_out), 32'h00009);

      // Reset mid-conversion
      accept(16'd54321, t0);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_bcd", 32'(bcd_out), 32'h00000);
`ifdef BCD_CVT_NDIG_EN
      chk("midrst_ndig", 32'(ndig), 32'd1);
`endif
      @(negedge clk);
      rst = 1'b0;
      d0  = done_cnt;
      repeat (20) @(negedge clk);
      chk("midrst_nodone", 32'(done_cnt - d0), 32'd0);
      accept(16'd7, t0);
      wait_done(t1);
      chk("bcd_7", 32'(bcd_out), 32'h00007);

      // Back-to-back sweep over boundaries and a strided subset
      sweep_q = '{16'd0, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000,
                  16'd9999, 16'd10000, 16'd59999, 16'd60000, 16'd65534, 16'd65535};
      for (int i = 0; i < 1200; i++)
         sweep_q.push_back(16'((i * 54613 + 17) % 65536));
      @(negedge clk);
      start  = 1'b1;
      bin_in = sweep_q[0];
      d0     = done_cnt;
      t1     = 0;
      for (int i = 0; i < sweep_q.size(); i++) begin
         wait_done(t2);
         chk("sweep_bcd", 32'(bcd_out), 32'(to_bcd(int'(sweep_q[i]))));
         if (i > 0)
            chk("sweep_spacing", 32'(t2 - t1), 32'd17);
         t1 = t2;
         if (i + 1 < sweep_q.size())
            bin_in = sweep_q[i+1];
         else
            start = 1'b0;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      chk("sweep_count", 32'(done_cnt - d0), 32'(sweep_q.size()));

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
